str_wrt_buf: RTL and testbench
==============================

Name: str_wrt_buf

Overview:
- Post-commit store write buffer between the store queue (committed, issued stores) and the data cache port of the memory system.
- Holds committed stores in FIFO order, drives them to the cache one at a time over a req/ack handshake, and gives same-cycle store-to-load forwarding on buffered data.
- Committed stores are architectural, so `flsh` never squashes buffer contents; the buffer keeps draining.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 16, address width.
- DW, 16, data width.
- IW, 6, store index (ROB tag) width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flsh  in  1  misprediction flush; does not clear entries; blocks forwarding for that cycle only.
- str_iss  in  1  committed store valid from the store queue.
- str_addr  in  AW  store address.
- str_data  in  DW  store data.
- str_indx  in  IW  store index tag.
- wb_full  out  1  no free entry; upstream must hold `str_iss` low while this is set.
- wb_empty  out  1  no valid entries.
- wb_cnt  out  $clog2(DEPTH)+1  occupancy.
- mem_wrt  out  1  write request to cache.
- mem_addr  out  AW  head entry address.
- mem_data  out  DW  head entry data.
- mem_indx  out  IW  head entry tag.
- mem_ack  in  1  cache accepted the write this cycle.
- ld_chk  in  1  load forwarding lookup valid.
- ld_addr  in  AW  load address.
- fwd_hit  out  1  combinational; a buffered store matches `ld_addr`.
- fwd_data  out  DW  data of the youngest matching entry.

Behaviour:
- Storage:
  - Circular array with `head`/`tail` pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate occupancy counter; full = (cnt == DEPTH), empty = (cnt == 0).
- Reset (rst=1 at posedge):
  - head=tail=cnt=0, all valid bits 0, state=IDLE.
  - Outputs: mem_wrt=0, wb_empty=1, wb_full=0, wb_cnt=0, fwd_hit=0.
  - mem_addr, mem_data, mem_indx, fwd_data = 0.
  - A reset mid-drain discards all entries, including one already being requested.
- Push:
  - When str_iss=1 and wb_full=0, write entry[tail] and set valid; tail+1; cnt+1.
  - str_iss while wb_full=1 is dropped; the `ifdef ASSERT` check flags it.
  - Full is evaluated on registered cnt only. A pop in the same cycle does not free a slot for a push until the next cycle.
- FSM, 2 states:
  - IDLE: mem_wrt=0. Move to REQ when cnt becomes nonzero. A push into an empty buffer raises mem_wrt on the following cycle, so push-to-request latency is 1 cycle.
  - REQ: mem_wrt=1; mem_addr/data/indx show entry[head] and stay stable until ack.
    - On mem_ack=1: clear valid[head]; head+1; cnt-1.
    - After an ack, go to IDLE if the post-update cnt is 0, else stay in REQ. Back-to-back writes therefore issue at one per cycle when ack is held high.
  - mem_ack in IDLE is ignored.
- Simultaneous push and pop: cnt unchanged, both pointers advance.
- Forwarding:
  - Compare ld_addr against every valid entry.
  - fwd_hit = ld_chk & !flsh & any match.
  - fwd_data = data of the match nearest tail, i.e. the youngest store.
  - The head entry remains forwardable in the ack cycle; it is removed at the clock edge.
  - A push in the same cycle is not visible to forwarding until the next cycle.
- flsh:
  - No effect on pointers, FSM or cnt.
  - Forces fwd_hit=0 for that cycle, because the load being checked is on the squashed path.

Optional Feature:
- WB_COALESCE_EN: store coalescing.
- Defined:
  - A push whose str_addr equals the address of the youngest valid entry overwrites that entry's data and indx in place. tail and cnt are unchanged.
  - Exception: if that youngest entry is head and the FSM is in REQ, it is in flight, so a new entry is allocated instead.
  - Coalescing is allowed even when wb_full=1.
- Undefined: every accepted push allocates a new entry.

Test Plan:
- Reset, then push addr 0x0010 data 0xAAAA indx 0x04 with mem_ack=0.
  - Next cycle: mem_wrt=1, mem_addr=0x0010, mem_data=0xAAAA, wb_cnt=1.
  - Then ack: wb_empty=1 and mem_wrt=0 on the following cycle.
- Push 4 stores to 0x0020..0x0023 with ack held low.
  - wb_full=1 after the 4th push.
  - A 5th push is dropped and wb_cnt stays 4.
  - Hold ack high: drains in order 0x0020, 0x0021, 0x0022, 0x0023 on consecutive cycles.
  - With DEPTH=4, head wraps to 0.
- Store 0x0030←0x1111, then 0x0030←0x2222 (coalescing disabled), then ld_chk ld_addr=0x0030.
  - fwd_hit=1, fwd_data=0x2222.
  - ld_addr=0x0031 gives fwd_hit=0.
- With 2 entries buffered, assert flsh=1 together with ld_chk on a matching address.
  - fwd_hit=0 that cycle.
  - wb_cnt stays 2 and draining continues unaffected.
- In REQ with cnt=2, pulse rst=1 for one cycle.
  - Next cycle: mem_wrt=0, wb_cnt=0, wb_empty=1.
  - A subsequent push restarts from entry 0.
- WB_COALESCE_EN defined: push 0x0040←0x0001 with ack=0, then 0x0050←0x0002, then 0x0050←0x0003.
  - wb_cnt=2; the entry for 0x0050 holds 0x0003.
  - Pushing 0x0040 again while it is head in REQ allocates a new entry, giving wb_cnt=3.

Source files
------------

// File: rtl/str_wrt_buf.sv
// Post-commit store write buffer: FIFO drain to the cache with store-to-load forwarding.
// Optional store coalescing into the youngest entry is enabled by defining WB_COALESCE_EN.
module str_wrt_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int IW    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flsh,
  input  logic                     str_iss,
  input  logic [AW-1:0]            str_addr,
  input  logic [DW-1:0]            str_data,
  input  logic [IW-1:0]            str_indx,
  output logic                     wb_full,
  output logic                     wb_empty,
  output logic [$clog2(DEPTH):0]   wb_cnt,
  output logic                     mem_wrt,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic [IW-1:0]            mem_indx,
  input  logic                     mem_ack,
  input  logic                     ld_chk,
  input  logic [AW-1:0]            ld_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} st_t;

  st_t st_q, st_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [IW-1:0] indx_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic full, pop, push, coal;
  logic any_hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;

  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = (st_q == REQ) & mem_ack;

`ifdef WB_COALESCE_EN
  logic [PW-1:0] yng;
  assign yng  = tail_q - PW'(1);
  // The in-flight head must not change under the cache, so it never absorbs a store.
  assign coal = str_iss & (cnt_q != '0) & vld_q[yng]
              & (addr_q[yng] == str_addr)
              & !((yng == head_q) & (st_q == REQ));
`else
  assign coal = 1'b0;
`endif

  assign push = str_iss & !full & !coal;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Request whenever anything remains after this cycle's updates.
  always_comb begin
    st_d = (cnt_d != '0) ? REQ : IDLE;
  end

  // Cache request outputs show the head entry only while requesting.
  always_comb begin
    mem_wrt  = (st_q == REQ);
    mem_addr = '0;
    mem_data = '0;
    mem_indx = '0;
    if (st_q == REQ) begin
      mem_addr = addr_q[head_q];
      mem_data = data_q[head_q];
      mem_indx = indx_q[head_q];
    end
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (push) begin
        addr_q[tail_q] <= str_addr;
        data_q[tail_q] <= str_data;
        indx_q[tail_q] <= str_indx;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + PW'(1);
      end
`ifdef WB_COALESCE_EN
      if (coal) begin
        data_q[yng] <= str_data;
        indx_q[yng] <= str_indx;
      end
`endif
    end
  end

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (vld_q[idx] && (addr_q[idx] == ld_addr)) begin
        any_hit  = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign fwd_hit  = ld_chk & !flsh & any_hit;
  assign fwd_data = fwd_hit ? hit_data : '0;

  assign wb_full  = full;
  assign wb_empty = (cnt_q == '0);
  assign wb_cnt   = cnt_q;

`ifdef ASSERT
  // A store offered to a full buffer that cannot coalesce is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(str_iss && full && !coal))
        else $error("str_wrt_buf: store dropped while full");
    end
  end
`endif

endmodule

// File: tb/tb_str_wrt_buf.sv
// Directed bench for str_wrt_buf.
// Coalescing steps run only when WB_COALESCE_EN is defined.
module tb_str_wrt_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flsh;
  logic        str_iss;
  logic [15:0] str_addr;
  logic [15:0] str_data;
  logic [5:0]  str_indx;
  logic        wb_full;
  logic        wb_empty;
  logic [2:0]  wb_cnt;
  logic        mem_wrt;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [5:0]  mem_indx;
  logic        mem_ack;
  logic        ld_chk;
  logic [15:0] ld_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  int total = 0;
  int bad   = 0;

  str_wrt_buf dut (
    .clk(clk), .rst(rst), .flsh(flsh),
    .str_iss(str_iss), .str_addr(str_addr),
    .str_data(str_data), .str_indx(str_indx),
    .wb_full(wb_full), .wb_empty(wb_empty),
    .wb_cnt(wb_cnt), .mem_wrt(mem_wrt),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_indx(mem_indx), .mem_ack(mem_ack),
    .ld_chk(ld_chk), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
  endtask

  task automatic put(input logic [15:0] a,
                     input logic [15:0] d,
                     input logic [5:0] x);
    str_iss  = 1'b1;
    str_addr = a;
    str_data = d;
    str_indx = x;
  endtask

  initial begin
    rst = 1'b1; flsh = 1'b0; str_iss = 1'b0;
    str_addr = '0; str_data = '0; str_indx = '0;
    mem_ack = 1'b0; ld_chk = 1'b0; ld_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    ld_chk = 1'b1;
    #1;
    chk("rst_wrt", mem_wrt, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_full", wb_full, 0);
    chk("rst_cnt", wb_cnt, 0);
    chk("rst_fwd", fwd_hit, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fdata", fwd_data, 0);
    ld_chk = 1'b0;

    // single store, 1-cycle push-to-request latency
    put(16'h0010, 16'hAAAA, 6'h04);
    chk("pre_wrt", mem_wrt, 0);
    tick();
    str_iss = 1'b0;
    chk("one_wrt", mem_wrt, 1);
    chk("one_addr", mem_addr, 16'h0010);
    chk("one_data", mem_data, 16'hAAAA);
    chk("one_indx", mem_indx, 6'h04);
    chk("one_cnt", wb_cnt, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("one_empty", wb_empty, 1);
    chk("one_idle", mem_wrt, 0);

    // fill to full, drop fifth, drain back-to-back
    for (int i = 0; i < 4; i++) begin
      put(16'h0020 + 16'(i), 16'hB000 + 16'(i), 6'(i));
      tick();
    end
    str_iss = 1'b0;
    chk("fill_full", wb_full, 1);
    chk("fill_cnt", wb_cnt, 4);
    put(16'h0024, 16'hB004, 6'h04);
    tick();
    str_iss = 1'b0;
    chk("drop_cnt", wb_cnt, 4);
    chk("drop_full", wb_full, 1);
    chk("drop_head", mem_addr, 16'h0020);
    mem_ack = 1'b1;
    #1;
    chk("drain0", mem_addr, 16'h0020);
    tick();
    chk("drain1", mem_addr, 16'h0021);
    chk("drain1_cnt", wb_cnt, 3);
    tick();
    chk("drain2", mem_addr, 16'h0022);
    tick();
    chk("drain3", mem_addr, 16'h0023);
    chk("drain3_dat", mem_data, 16'hB003);
    tick();
    mem_ack = 1'b0;
    chk("drain_empty", wb_empty, 1);
    chk("drain_wrt", mem_wrt, 0);

    // forwarding picks the youngest match
    put(16'h0030, 16'h1111, 6'h10);
    tick();
    put(16'h0030, 16'h2222, 6'h11);
    tick();
    str_iss = 1'b0;
    chk("fw_cnt", wb_cnt, 2);
    ld_chk = 1'b1;
    ld_addr = 16'h0030;
    #1;
    chk("fw_hit", fwd_hit, 1);
    chk("fw_data", fwd_data, 16'h2222);
    ld_addr = 16'h0031;
    #1;
    chk("fw_miss", fwd_hit, 0);

    // flush blocks forwarding for one cycle only
    ld_addr = 16'h0030;
    flsh = 1'b1;
    #1;
    chk("fl_hit", fwd_hit, 0);
    tick();
    flsh = 1'b0;
    #1;
    chk("fl_cnt", wb_cnt, 2);
    chk("fl_wrt", mem_wrt, 1);
    chk("fl_head", mem_data, 16'h1111);
    chk("fl_after", fwd_hit, 1);

    // head stays forwardable during its ack cycle
    mem_ack = 1'b1;
    tick();
    chk("ack_cnt", wb_cnt, 1);
    chk("ack_head", mem_data, 16'h2222);
    chk("ack_fwd", fwd_hit, 1);
    chk("ack_fdat", fwd_data, 16'h2222);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("ack_gone", fwd_hit, 0);
    chk("ack_empty", wb_empty, 1);
    ld_chk = 1'b0;

    // reset mid-drain discards everything
    put(16'h0060, 16'h6000, 6'h20);
    tick();
    put(16'h0061, 16'h6001, 6'h21);
    tick();
    str_iss = 1'b0;
    chk("mr_cnt", wb_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_wrt", mem_wrt, 0);
    chk("mr_cnt0", wb_cnt, 0);
    chk("mr_empty", wb_empty, 1);
    put(16'h0070, 16'h7777, 6'h22);
    tick();
    str_iss = 1'b0;
    chk("mr_addr", mem_addr, 16'h0070);
    chk("mr_data", mem_data, 16'h7777);
    chk("mr_cnt1", wb_cnt, 1);

    // simultaneous push and pop
    put(16'h0081, 16'h8181, 6'h23);
    mem_ack = 1'b1;
    tick();
    str_iss = 1'b0;
    chk("pp_cnt", wb_cnt, 1);
    chk("pp_addr", mem_addr, 16'h0081);
    chk("pp_wrt", mem_wrt, 1);
    tick();
    mem_ack = 1'b0;
    chk("pp_empty", wb_empty, 1);

`ifdef WB_COALESCE_EN
    put(16'h0040, 16'h0001, 6'h01);
    tick();
    put(16'h0050, 16'h0002, 6'h02);
    tick();
    put(16'h0050, 16'h0003, 6'h03);
    tick();
    str_iss = 1'b0;
    chk("co_cnt", wb_cnt, 2);
    ld_chk = 1'b1;
    ld_addr = 16'h0050;
    #1;
    chk("co_data", fwd_data, 16'h0003);
    ld_chk = 1'b0;
    put(16'h0040, 16'h0004, 6'h04);
    tick();
    str_iss = 1'b0;
    chk("co_new", wb_cnt, 3);
    chk("co_head", mem_data, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
